// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 encodings used by fetch, decode, execute and memory.
// Holds instruction codes, ALU function codes, condition function codes and
// the special register IDs.
package y86_pkg;

  // Instruction codes
  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  // ALU function codes (ifun of OPq)
  typedef enum logic [1:0] {
    ALUADD = 2'd0,
    ALUSUB = 2'd1,
    ALUAND = 2'd2,
    ALUXOR = 2'd3
  } alufun_e;

  // Condition function codes (ifun of jXX / cmovXX)
  localparam logic [3:0] C_YES = 4'h0;
  localparam logic [3:0] C_LE  = 4'h1;
  localparam logic [3:0] C_L   = 4'h2;
  localparam logic [3:0] C_E   = 4'h3;
  localparam logic [3:0] C_NE  = 4'h4;
  localparam logic [3:0] C_GE  = 4'h5;
  localparam logic [3:0] C_G   = 4'h6;

  // Special register IDs
  localparam logic [3:0] REG_NONE = 4'hF;
  localparam logic [3:0] RRSP     = 4'h4;

endpackage

// File: rtl/exec_alu.sv
// exec_alu: combinational Y86-64 ALU.
// Ports:
//   aluA, aluB  in  WIDTH  operands (result is B op A)
//   alufun      in  2      ALU function (add/sub/and/xor)
//   valE        out WIDTH  result, modulo 2^WIDTH
//   zf, sf, of  out 1      flags derived from the result
module exec_alu #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] aluA,
  input  logic [WIDTH-1:0] aluB,
  input  logic [1:0]       alufun,
  output logic [WIDTH-1:0] valE,
  output logic             zf,
  output logic             sf,
  output logic             of
);
  import y86_pkg::*;

  logic sa, sb;
  assign sa = aluA[WIDTH-1];
  assign sb = aluB[WIDTH-1];

  always_comb begin
    valE = '0;
    of   = 1'b0;
    case (alufun_e'(alufun))
      ALUADD: begin
        valE = aluB + aluA;
        // Overflow when both operands share a sign the result does not
        of   = (sa == sb) && (valE[WIDTH-1] != sa);
      end
      ALUSUB: begin
        valE = aluB - aluA;
        // Overflow when operand signs differ and the result flips away from B
        of   = (sb != sa) && (valE[WIDTH-1] != sb);
      end
      ALUAND: valE = aluB & aluA;
      ALUXOR: valE = aluB ^ aluA;
      default: valE = '0;
    endcase
  end

  assign zf = (valE == '0);
  assign sf = valE[WIDTH-1];

endmodule

// File: rtl/execute_stage.sv
// execute_stage: Y86-64 pipelined execute stage.
// Selects ALU operands from decoded values, computes valE and the jump/cmov
// condition, owns the condition-code register and registers the result into
// the E/M pipeline register. valE/dstE are also forwarded combinationally.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/icode/ifun      instruction at stage input
//   in_valA/valB/valC        operands from decode / fetch
//   in_dstE/dstM             destination register IDs
//   stall, bubble            hold / insert NOP into the E/M register
//   cc_inhibit               suppress CC update
//   fwd_valE/fwd_dstE        combinational forwarding to decode
//   m_*                      E/M pipeline register outputs
//   cc_zf/cc_sf/cc_of        current condition codes
module execute_stage #(
  parameter int         WIDTH    = 64,
  parameter logic [3:0] REG_NONE = y86_pkg::REG_NONE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [3:0]       in_icode,
  input  logic [3:0]       in_ifun,
  input  logic [WIDTH-1:0] in_valA,
  input  logic [WIDTH-1:0] in_valB,
  input  logic [WIDTH-1:0] in_valC,
  input  logic [3:0]       in_dstE,
  input  logic [3:0]       in_dstM,
  input  logic             stall,
  input  logic             bubble,
  input  logic             cc_inhibit,
  output logic [WIDTH-1:0] fwd_valE,
  output logic [3:0]       fwd_dstE,
  output logic             m_valid,
  output logic [3:0]       m_icode,
  output logic             m_cnd,
  output logic [WIDTH-1:0] m_valE,
  output logic [WIDTH-1:0] m_valA,
  output logic [3:0]       m_dstE,
  output logic [3:0]       m_dstM,
  output logic             cc_zf,
  output logic             cc_sf,
  output logic             cc_of
);
  import y86_pkg::*;

  localparam logic [WIDTH-1:0] EIGHT = WIDTH'(8);

  logic [WIDTH-1:0] aluA, aluB, alu_valE, valE;
  logic [1:0]       alufun;
  logic             alu_zf, alu_sf, alu_of;
  logic             is_opq, op_ok;
  logic             cond_hit, cnd;
  logic [3:0]       dstE;
  logic             cc_we;

  logic             m_valid_q, m_valid_d;
  logic [3:0]       m_icode_q, m_icode_d;
  logic             m_cnd_q, m_cnd_d;
  logic [WIDTH-1:0] m_valE_q, m_valE_d;
  logic [WIDTH-1:0] m_valA_q, m_valA_d;
  logic [3:0]       m_dstE_q, m_dstE_d;
  logic [3:0]       m_dstM_q, m_dstM_d;
  logic             zf_q, zf_d, sf_q, sf_d, of_q, of_d;

  // ALU operand selection
  always_comb begin
    aluA = '0;
    case (in_icode)
      IOPQ, IRRMOVQ:             aluA = in_valA;
      IIRMOVQ, IRMMOVQ, IMRMOVQ: aluA = in_valC;
      ICALL, IPUSHQ:             aluA = '0 - EIGHT;
      IRET, IPOPQ:               aluA = EIGHT;
      default:                   aluA = '0;
    endcase
  end

  always_comb begin
    aluB = '0;
    case (in_icode)
      IRMMOVQ, IMRMOVQ, IOPQ, ICALL, IRET, IPUSHQ, IPOPQ: aluB = in_valB;
      default:                                            aluB = '0;
    endcase
  end

  assign is_opq = (in_icode == IOPQ);
  assign op_ok  = is_opq && (in_ifun <= 4'd3);
  assign alufun = is_opq ? in_ifun[1:0] : ALUADD;

  exec_alu #(.WIDTH(WIDTH)) u_alu (
    .aluA   (aluA),
    .aluB   (aluB),
    .alufun (alufun),
    .valE   (alu_valE),
    .zf     (alu_zf),
    .sf     (alu_sf),
    .of     (alu_of)
  );

  // An undefined OPq function yields zero rather than an aliased ALU op
  assign valE = (is_opq && !op_ok) ? '0 : alu_valE;

  // Condition evaluation uses the registered CC, i.e. flags of the previous OPq
  always_comb begin
    cond_hit = 1'b0;
    case (in_ifun)
      C_YES:   cond_hit = 1'b1;
      C_LE:    cond_hit = (sf_q ^ of_q) | zf_q;
      C_L:     cond_hit = sf_q ^ of_q;
      C_E:     cond_hit = zf_q;
      C_NE:    cond_hit = !zf_q;
      C_GE:    cond_hit = !(sf_q ^ of_q);
      C_G:     cond_hit = !(sf_q ^ of_q) && !zf_q;
      default: cond_hit = 1'b0;
    endcase
  end

  assign cnd = ((in_icode == IRRMOVQ) || (in_icode == IJXX)) && cond_hit;

  // A cmov that fails its condition must not write any register
  always_comb begin
    dstE = in_dstE;
    if (!in_valid)
      dstE = REG_NONE;
    else if ((in_icode == IRRMOVQ) && !cnd)
      dstE = REG_NONE;
  end

  assign fwd_valE = valE;
  assign fwd_dstE = dstE;

  assign cc_we = in_valid && op_ok && !cc_inhibit && !stall && !bubble;

  // E/M register and CC next state
  always_comb begin
    m_valid_d = m_valid_q;
    m_icode_d = m_icode_q;
    m_cnd_d   = m_cnd_q;
    m_valE_d  = m_valE_q;
    m_valA_d  = m_valA_q;
    m_dstE_d  = m_dstE_q;
    m_dstM_d  = m_dstM_q;
    zf_d      = zf_q;
    sf_d      = sf_q;
    of_d      = of_q;
    if (!stall) begin
      if (!in_valid || bubble) begin
        m_valid_d = 1'b0;
        m_icode_d = INOP;
        m_cnd_d   = 1'b0;
        m_valE_d  = '0;
        m_valA_d  = '0;
        m_dstE_d  = REG_NONE;
        m_dstM_d  = REG_NONE;
      end else begin
        m_valid_d = 1'b1;
        m_icode_d = in_icode;
        m_cnd_d   = cnd;
        m_valE_d  = valE;
        m_valA_d  = in_valA;
        m_dstE_d  = dstE;
        m_dstM_d  = in_dstM;
      end
    end
    if (cc_we) begin
      zf_d = alu_zf;
      sf_d = alu_sf;
      of_d = alu_of;
    end
  end

  // E/M pipeline register boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      m_icode_q <= INOP;
      m_cnd_q   <= 1'b0;
      m_valE_q  <= '0;
      m_valA_q  <= '0;
      m_dstE_q  <= REG_NONE;
      m_dstM_q  <= REG_NONE;
      zf_q      <= 1'b1;
      sf_q      <= 1'b0;
      of_q      <= 1'b0;
    end else begin
      m_valid_q <= m_valid_d;
      m_icode_q <= m_icode_d;
      m_cnd_q   <= m_cnd_d;
      m_valE_q  <= m_valE_d;
      m_valA_q  <= m_valA_d;
      m_dstE_q  <= m_dstE_d;
      m_dstM_q  <= m_dstM_d;
      zf_q      <= zf_d;
      sf_q      <= sf_d;
      of_q      <= of_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_icode = m_icode_q;
  assign m_cnd   = m_cnd_q;
  assign m_valE  = m_valE_q;
  assign m_valA  = m_valA_q;
  assign m_dstE  = m_dstE_q;
  assign m_dstM  = m_dstM_q;
  assign cc_zf   = zf_q;
  assign cc_sf   = sf_q;
  assign cc_of   = of_q;

endmodule

// File: tb/tb_execute_stage.sv
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [3:0]  in_icode, in_ifun;
  logic [63:0] in_valA, in_valB, in_valC;
  logic [3:0]  in_dstE, in_dstM;
  logic        stall, bubble, cc_inhibit;
  logic [63:0] fwd_valE;
  logic [3:0]  fwd_dstE;
  logic        m_valid;
  logic [3:0]  m_icode;
  logic        m_cnd;
  logic [63:0] m_valE, m_valA;
  logic [3:0]  m_dstE, m_dstM;
  logic        cc_zf, cc_sf, cc_of;

  execute_stage #(.WIDTH(64), .REG_NONE(4'hF)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_icode   (in_icode),
    .in_ifun    (in_ifun),
    .in_valA    (in_valA),
    .in_valB    (in_valB),
    .in_valC    (in_valC),
    .in_dstE    (in_dstE),
    .in_dstM    (in_dstM),
    .stall      (stall),
    .bubble     (bubble),
    .cc_inhibit (cc_inhibit),
    .fwd_valE   (fwd_valE),
    .fwd_dstE   (fwd_dstE),
    .m_valid    (m_valid),
    .m_icode    (m_icode),
    .m_cnd      (m_cnd),
    .m_valE     (m_valE),
    .m_valA     (m_valA),
    .m_dstE     (m_dstE),
    .m_dstM     (m_dstM),
    .cc_zf      (cc_zf),
    .cc_sf      (cc_sf),
    .cc_of      (cc_of)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: expected E/M contents and condition codes
  logic        e_valid;
  logic [3:0]  e_icode;
  logic        e_cnd;
  logic [63:0] e_valE, e_valA;
  logic [3:0]  e_dstE, e_dstM;
  logic        e_zf, e_sf, e_of;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Instruction semantics straight from the ISA: what each instruction computes
  task automatic ref_exec(output logic [63:0] v, output logic c, output logic [3:0] d,
                          output logic we, output logic nz, output logic ns, output logic no);
    logic [64:0] wide;
    logic        lt;
    v  = 64'd0;
    no = 1'b0;
    c  = 1'b0;
    case (in_icode)
      4'h6: case (in_ifun)
        4'd0: begin
          wide = {in_valB[63], in_valB} + {in_valA[63], in_valA};
          v = wide[63:0]; no = (wide[64] != wide[63]);
        end
        4'd1: begin
          wide = {in_valB[63], in_valB} - {in_valA[63], in_valA};
          v = wide[63:0]; no = (wide[64] != wide[63]);
        end
        4'd2: v = in_valB & in_valA;
        4'd3: v = in_valB ^ in_valA;
        default: v = 64'd0;
      endcase
      4'h2:       v = in_valA;
      4'h3:       v = in_valC;
      4'h4, 4'h5: v = in_valB + in_valC;
      4'h8, 4'hA: v = in_valB - 64'd8;
      4'h9, 4'hB: v = in_valB + 64'd8;
      default:    v = 64'd0;
    endcase
    nz = (v == 64'd0);
    ns = v[63];
    lt = e_sf ^ e_of;
    if (in_icode == 4'h2 || in_icode == 4'h7) begin
      case (in_ifun)
        4'd0: c = 1'b1;
        4'd1: c = lt | e_zf;
        4'd2: c = lt;
        4'd3: c = e_zf;
        4'd4: c = !e_zf;
        4'd5: c = !lt;
        4'd6: c = !lt && !e_zf;
        default: c = 1'b0;
      endcase
    end
    if (!in_valid || (in_icode == 4'h2 && !c)) d = 4'hF;
    else d = in_dstE;
    we = in_valid && in_icode == 4'h6 && in_ifun <= 4'd3 && !cc_inhibit && !stall && !bubble;
  endtask

  // One clock: check forwarding, clock, advance model, check registers
  task automatic cycle(input string tag);
    logic [63:0] v;
    logic c, we, nz, ns, no;
    logic [3:0] d;
    #1;
    ref_exec(v, c, d, we, nz, ns, no);
    chk({tag, ".fwd_valE"}, fwd_valE, v);
    chk({tag, ".fwd_dstE"}, {60'd0, fwd_dstE}, {60'd0, d});
    @(posedge clk);
    if (rst) begin
      e_valid = 0; e_icode = 4'h1; e_cnd = 0; e_valE = 0; e_valA = 0;
      e_dstE = 4'hF; e_dstM = 4'hF; e_zf = 1; e_sf = 0; e_of = 0;
    end else begin
      if (!stall) begin
        if (!in_valid || bubble) begin
          e_valid = 0; e_icode = 4'h1; e_cnd = 0; e_dstE = 4'hF; e_dstM = 4'hF;
        end else begin
          e_valid = 1; e_icode = in_icode; e_cnd = c; e_valE = v; e_valA = in_valA;
          e_dstE = d; e_dstM = in_dstM;
        end
      end
      if (we) begin e_zf = nz; e_sf = ns; e_of = no; end
    end
    #1;
    chk({tag, ".m_valid"}, {63'd0, m_valid}, {63'd0, e_valid});
    chk({tag, ".m_icode"}, {60'd0, m_icode}, {60'd0, e_icode});
    chk({tag, ".m_cnd"},   {63'd0, m_cnd},   {63'd0, e_cnd});
    chk({tag, ".m_dstE"},  {60'd0, m_dstE},  {60'd0, e_dstE});
    chk({tag, ".m_dstM"},  {60'd0, m_dstM},  {60'd0, e_dstM});
    chk({tag, ".cc"}, {61'd0, cc_zf, cc_sf, cc_of}, {61'd0, e_zf, e_sf, e_of});
    if (e_valid) begin
      chk({tag, ".m_valE"}, m_valE, e_valE);
      chk({tag, ".m_valA"}, m_valA, e_valA);
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] cv,
                       input logic [3:0] de, input logic [3:0] dm);
    in_valid = 1; in_icode = ic; in_ifun = fn;
    in_valA = a; in_valB = b; in_valC = cv; in_dstE = de; in_dstM = dm;
  endtask

  initial begin
    rst = 1; in_valid = 0; in_icode = 4'h1; in_ifun = 0;
    in_valA = 0; in_valB = 0; in_valC = 0; in_dstE = 4'hF; in_dstM = 4'hF;
    stall = 0; bubble = 0; cc_inhibit = 0;
    e_valid = 0; e_icode = 4'h1; e_cnd = 0; e_valE = 0; e_valA = 0;
    e_dstE = 4'hF; e_dstM = 4'hF; e_zf = 1; e_sf = 0; e_of = 0;
    @(negedge clk);

    // Reset state
    cycle("reset");
    chk("reset.m_valid", {63'd0, m_valid}, 64'd0);
    chk("reset.m_icode", {60'd0, m_icode}, 64'h1);
    chk("reset.m_valE", m_valE, 64'd0);
    chk("reset.cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'b100);
    rst = 0;

    // OPq add overflowing into the sign bit
    drive(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'h2, 4'hF);
    cycle("add");
    chk("add.valE", m_valE, 64'h8000_0000_0000_0000);
    chk("add.cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'b011);

    // sub to zero, then jle / jne
    drive(4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 4'h3, 4'hF);
    cycle("sub");
    chk("sub.valE", m_valE, 64'd0);
    chk("sub.zf", {63'd0, cc_zf}, 64'd1);
    drive(4'h7, 4'h1, 64'd0, 64'd0, 64'h40, 4'hF, 4'hF);
    cycle("jle");
    chk("jle.cnd", {63'd0, m_cnd}, 64'd1);
    drive(4'h7, 4'h4, 64'd0, 64'd0, 64'h40, 4'hF, 4'hF);
    cycle("jne");
    chk("jne.cnd", {63'd0, m_cnd}, 64'd0);

    // cmovl with SF=OF=0 fails, then with SF=1 succeeds
    drive(4'h2, 4'h2, 64'h55, 64'd0, 64'd0, 4'h3, 4'hF);
    #1 chk("cmovl0.fwd_dstE", {60'd0, fwd_dstE}, 64'hF);
    cycle("cmovl0");
    chk("cmovl0.dstE", {60'd0, m_dstE}, 64'hF);
    chk("cmovl0.cnd", {63'd0, m_cnd}, 64'd0);
    drive(4'h6, 4'h1, 64'd1, 64'd0, 64'd0, 4'h1, 4'hF);
    cycle("neg");
    drive(4'h2, 4'h2, 64'h55, 64'd0, 64'd0, 4'h3, 4'hF);
    cycle("cmovl1");
    chk("cmovl1.dstE", {60'd0, m_dstE}, 64'h3);
    chk("cmovl1.cnd", {63'd0, m_cnd}, 64'd1);

    // Stack pointer arithmetic and irmovq leave CC alone (ZF=0 SF=1 OF=0)
    drive(4'hA, 4'h0, 64'h1234, 64'h100, 64'd0, 4'h4, 4'hF);
    cycle("pushq");
    chk("pushq.valE", m_valE, 64'hF8);
    drive(4'hB, 4'h0, 64'h100, 64'h100, 64'd0, 4'h4, 4'h7);
    cycle("popq");
    chk("popq.valE", m_valE, 64'h108);
    drive(4'h3, 4'h0, 64'd0, 64'd0, 64'h2A, 4'h5, 4'hF);
    cycle("irmovq");
    chk("irmovq.valE", m_valE, 64'h2A);
    chk("irmovq.cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'b010);

    // Stall holds; stall+bubble holds; bubble alone loads a NOP
    drive(4'h3, 4'h0, 64'd0, 64'd0, 64'h77, 4'h6, 4'hF);
    cycle("load77");
    drive(4'h6, 4'h0, 64'd3, 64'd4, 64'd0, 4'h1, 4'hF);
    stall = 1;
    cycle("stall1");
    in_valA = 64'd9;
    cycle("stall2");
    chk("stall.valE", m_valE, 64'h77);
    bubble = 1;
    cycle("stallbub");
    chk("stallbub.valid", {63'd0, m_valid}, 64'd1);
    stall = 0;
    cycle("bubble");
    chk("bubble.valid", {63'd0, m_valid}, 64'd0);
    chk("bubble.dst", {56'd0, m_dstE, m_dstM}, 64'hFF);
    bubble = 0;

    // cc_inhibit: xor to zero must not set ZF; undefined OPq function
    drive(4'h6, 4'h3, 64'hABCD, 64'hABCD, 64'd0, 4'h2, 4'hF);
    cc_inhibit = 1;
    cycle("inhibit");
    chk("inhibit.valE", m_valE, 64'd0);
    chk("inhibit.zf", {63'd0, cc_zf}, 64'd0);
    cc_inhibit = 0;
    drive(4'h6, 4'h5, 64'd3, 64'd0, 64'd0, 4'h2, 4'hF);
    cycle("badfun");
    chk("badfun.valE", m_valE, 64'd0);

    // Reset mid-stream
    drive(4'h6, 4'h0, 64'd1, 64'd2, 64'd0, 4'h2, 4'hF);
    rst = 1;
    cycle("midrst");
    chk("midrst.cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'b100);
    rst = 0;

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      in_valid   = ($urandom_range(9) != 0);
      in_icode   = 4'($urandom_range(15));
      if ($urandom_range(2) == 0) in_icode = 4'h6;
      else if ($urandom_range(2) == 0) in_icode = 4'($urandom_range(1) ? 2 : 7);
      in_ifun    = 4'($urandom_range(7));
      in_valA    = {$urandom, $urandom};
      in_valB    = ($urandom_range(3) == 0) ? in_valA : {$urandom, $urandom};
      if ($urandom_range(3) == 0) in_valA = {32'd0, $urandom} ^ 64'h8000_0000_0000_0000;
      in_valC    = {$urandom, $urandom};
      in_dstE    = 4'($urandom_range(15));
      in_dstM    = 4'($urandom_range(15));
      stall      = ($urandom_range(9) == 0);
      bubble     = ($urandom_range(9) == 0);
      cc_inhibit = ($urandom_range(9) == 0);
      rst        = ($urandom_range(49) == 0);
      cycle("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
